// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution path: pixel width, default
// image geometry and the line-buffer state encoding.
package conv_pkg;

  localparam int PIX_W          = 8;
  localparam int IMG_WIDTH_DEF  = 28;
  localparam int IMG_HEIGHT_DEF = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lb_state_t;

endpackage

// File: rtl/lb_line_mem.sv
// One image row of pixels: synchronous write, asynchronous read on the
// same address so the old value can be forwarded in the write cycle.
module lb_line_mem
  import conv_pkg::*;
#(
  parameter int DEPTH  = IMG_WIDTH_DEF,
  parameter int DATA_W = PIX_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Row storage; contents are never reset, consumers gate them by row count
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_line_buffer.sv
// Line buffer feeding the 3x3 convolution kernel. Turns a raster pixel
// stream into 3-pixel columns (rows y-2, y-1, y) and flags the columns that
// complete a fully populated 3x3 window.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_W     = PIX_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              out_stall,
  output logic              shift,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic              win_valid,
  output logic              frame_done,
  output logic              err_sof
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  lb_state_t         state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              shift_q, shift_d;
  logic              win_q, win_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [DATA_W-1:0] out_c_q, out_c_d;

  logic              accept;
  logic              proc;
  logic              last_pix;
  logic [CW-1:0]     x;
  logic [RW-1:0]     y;
  logic [DATA_W-1:0] line1_rd;
  logic [DATA_W-1:0] line2_rd;

  // Ready depends only on stall and state, never on pix_valid
  always_comb begin
    pix_ready = ~out_stall & (state_q != DONE);
  end

  assign accept = pix_valid & pix_ready;

  // Effective pixel position: a start-of-frame pixel is always (row 0, col 0);
  // in IDLE only start-of-frame pixels are processed, others are dropped
  always_comb begin
    proc     = accept & (pix_sof | (state_q == RUN));
    x        = pix_sof ? '0 : col_q;
    y        = pix_sof ? '0 : row_q;
    last_pix = proc & (x == COL_LAST) & (y == ROW_LAST);
  end

  // Frame sequencing: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (proc) state_d = RUN;
      RUN:     if (last_pix) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position counters, cleared on the way back to IDLE
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == DONE) begin
      col_d = '0;
      row_d = '0;
    end else if (proc) begin
      if (x == COL_LAST) begin
        col_d = '0;
        row_d = (y == ROW_LAST) ? '0 : y + RW'(1);
      end else begin
        col_d = x + CW'(1);
        row_d = y;
      end
    end
  end

  // Column outputs; rows not yet received in this frame read as zero
  always_comb begin
    shift_d = proc;
    win_d   = proc & (y >= ROW_TWO) & (x >= COL_TWO);
    err_d   = proc & pix_sof & (state_q == RUN);
    done_d  = (state_q == DONE);
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    out_c_d = out_c_q;
    if (proc) begin
      out_c_d = pix_data;
      out_b_d = (y >= ROW_ONE) ? line1_rd : '0;
      out_a_d = (y >= ROW_TWO) ? line2_rd : '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      shift_q <= 1'b0;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_a_q <= '0;
      out_b_q <= '0;
      out_c_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      out_c_q <= out_c_d;
    end
  end

  // line1 holds row y-1, line2 holds row y-2; both shift down on each pixel
  lb_line_mem #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_line1 (
    .clk   (CLK),
    .we    (proc),
    .addr  (x),
    .wdata (pix_data),
    .rdata (line1_rd)
  );

  lb_line_mem #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .AW(CW)) u_line2 (
    .clk   (CLK),
    .we    (proc),
    .addr  (x),
    .wdata (line1_rd),
    .rdata (line2_rd)
  );

  assign shift      = shift_q;
  assign win_valid  = win_q;
  assign frame_done = done_q;
  assign err_sof    = err_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_c      = out_c_q;

endmodule
